dma_axi_rd_arbiter: RTL and testbench
=====================================

# dma_axi_rd_arbiter

Read-channel arbiter for the DMA_SG_Engine. It shares the single AXI4 read master port to DDR between two internal requesters: requester 0 is the descriptor fetcher, requester 1 is the MM2S data mover. It arbitrates AR requests round-robin, tags each request with the requester index in the ID MSB, and returns R beats to the owning requester by decoding `rid`. It also enforces a per-requester outstanding-burst limit.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: AXI address width.
- `DATA_WIDTH`, default 64: AXI data width.
- `ID_WIDTH`, default 4: master ID width. Requester-side IDs are `ID_WIDTH-1` bits wide.
- `MAX_OUTST`, default 4: maximum outstanding bursts per requester (1..15).

Ports:
- `ACLK`  in  1  clock; single clock domain.
- `ARESETN`  in  1  reset; asynchronous assert, active-low.
- `s0_arid`, `s1_arid`  in  ID_WIDTH-1  requester AR ID.
- `s0_araddr`, `s1_araddr`  in  ADDR_WIDTH  requester AR address.
- `s0_arlen`, `s1_arlen`  in  8  requester burst length minus one.
- `s0_arvalid`, `s1_arvalid`  in  1  requester AR valid.
- `s0_arready`, `s1_arready`  out  1  requester AR accept.
- `s0_rid`, `s1_rid`  out  ID_WIDTH-1  returned ID, with the MSB stripped.
- `s0_rdata`, `s1_rdata`  out  DATA_WIDTH  read data.
- `s0_rresp`, `s1_rresp`  out  2  read response.
- `s0_rlast`, `s1_rlast`  out  1  last beat of the burst.
- `s0_rvalid`, `s1_rvalid`  out  1  R beat valid.
- `s0_rready`, `s1_rready`  in  1  requester R ready.
- `m_arid`  out  ID_WIDTH  master AR ID; the MSB is the requester index.
- `m_araddr`  out  ADDR_WIDTH  master AR address.
- `m_arlen`  out  8  master AR burst length.
- `m_arvalid`  out  1  master AR valid.
- `m_arready`  in  1  master AR ready.
- `m_rid`  in  ID_WIDTH  master R ID.
- `m_rdata`  in  DATA_WIDTH  master R data.
- `m_rresp`  in  2  master R response.
- `m_rlast`  in  1  master R last.
- `m_rvalid`  in  1  master R valid.
- `m_rready`  out  1  master R ready.
- `busy`  out  1  high while any burst is outstanding or an AR is held.

## Operation
**AR output register (single slot)**
- The slot is free when `!m_arvalid || m_arready`.
- Requester i is eligible when `si_arvalid` is high and `outst[i] < MAX_OUTST`.

**Arbitration**
- Round-robin with a priority pointer `rr`. The reset value of `rr` is 0.
- If exactly one requester is eligible, that requester wins.
- If both are eligible, requester `rr` wins.
- After each accepted request, `rr` is set to the other requester (the non-winner).
- `si_arready` = slot free AND i is the winner. This is combinational; at most one `arready` is high in any cycle.

**Slot load**
- On acceptance, the slot loads `m_arid = {i, si_arid}`, `m_araddr`, and `m_arlen`, and sets `m_arvalid = 1`.
- `m_arvalid` is held, with all payload stable, until `m_arready` is sampled high.
- A new request may load in the same cycle as the `m_arready` handshake, giving back-to-back throughput.

**Outstanding counters**
- `outst[i]` is `$clog2(MAX_OUTST+1)` bits wide.
- It increments when requester i is accepted into the slot. This counts the held slot as outstanding.
- It decrements on `m_rvalid && m_rready && m_rlast` when `m_rid[ID_WIDTH-1] == i`.
- A simultaneous increment and decrement leaves the counter unchanged.
- The counter never exceeds `MAX_OUTST`; eligibility gating guarantees this.
- A decrement at zero is a protocol error: the counter saturates at 0, and a simulation assertion fires.

**R routing (combinational, zero latency)**
- `si_rvalid = m_rvalid && m_rid[ID_WIDTH-1] == i`.
- `m_rready = s<m_rid MSB>_rready`.
- `rdata`, `rresp`, `rlast`, and `rid[ID_WIDTH-2:0]` are fanned out to both requesters. Only the selected requester sees `rvalid` asserted.

**busy**
- `busy = m_arvalid || outst[0] != 0 || outst[1] != 0`.
- Software halt sequencing waits for `busy == 0`.

## Timing
- **Reset values:** `m_arvalid`, `m_arid`, `m_araddr`, `m_arlen`, `outst[0]`, `outst[1]`, and `rr` are all 0.
  - `s*_arready` is 0 because the slot is free but no requester is valid.
  - `s*_rvalid` and `m_rready` are 0 when `m_rvalid` is 0.
  - `busy` is 0.
- **AR latency:** acceptance at cycle N gives `m_arvalid` at cycle N+1. Sustained throughput is one AR per cycle.
- **R latency:** 0 cycles, combinational passthrough.
- **Mid-operation reset:** reset clears the slot and the counters immediately (asynchronous). In-flight R beats that arrive after reset are not tracked. The system guarantees the interconnect is reset together with the engine.
- **Once-valid rule:** requesters must not drop `arvalid` before `arready`. The arbiter may change its winner only between acceptances.

## Structure
- Add to `dma_sg_pkg`:
  - `REQ_DESC = 0` and `REQ_DATA = 1` constants.
  - An `ar_req_t` struct typedef (id, addr, len).
- One sub-module, `dma_outst_cnt`: an up/down saturating counter with a limit compare. It is instantiated twice.
- The top-level module holds the arbiter, the AR slot, and the R demux.

## Test plan
1. **Single request.** Reset, then `s0` issues addr `0x1000`, len 3, id 2 while `m_arready = 1`.
   - Expect `m_arid = 4'h2` and `m_araddr = 0x1000` one cycle later.
   - Return 4 beats with `rid = 2`. Only `s0_rvalid` pulses; `outst[0]` goes 1 → 0; `busy` then drops.
2. **Round-robin.** `s0` and `s1` both hold `arvalid` for 4 requests each, with `m_arready = 1`.
   - Expect grant order s0, s1, s0, s1, …
   - `m_arid` MSB alternates 0, 1, 0, 1, …
3. **Backpressure.** Hold `m_arready = 0` for 5 cycles.
   - `m_arvalid` and its payload stay stable.
   - Both `s*_arready` stay 0.
   - Release: the next request is accepted in the same cycle as the handshake.
4. **Outstanding limit.** With `MAX_OUTST = 4`, `s1` issues 5 ARs with no R traffic.
   - The 5th request stalls (`s1_arready = 0`) while `s0` is still granted.
   - One `rlast` with `rid = 4'h8` unblocks the 5th request the next cycle.
5. **R backpressure and simultaneous events.**
   - Interleave R beats for both IDs while `s1_rready = 0`: `m_rready` follows `s0_rready` or `s1_rready` according to the `rid` of each beat.
   - Issue an `rlast` in the same cycle as an AR acceptance for the same requester: the counter is unchanged.
6. **Asynchronous reset mid-burst.** Assert `ARESETN` low mid-burst with 2 bursts outstanding.
   - All outputs return to their reset values without waiting for a clock edge.
   - `busy = 0`.

Source files
------------

// File: rtl/dma_sg_pkg.sv
// Shared types and constants for the DMA_SG_Engine.
// Requester indices and the AR request bundle.
package dma_sg_pkg;

  localparam int REQ_DESC = 0;
  localparam int REQ_DATA = 1;

  // Storage widths for AR payload; instances use the low bits.
  localparam int AR_ID_MAX   = 16;
  localparam int AR_ADDR_MAX = 64;

  typedef struct packed {
    logic [AR_ID_MAX-1:0]   id;
    logic [AR_ADDR_MAX-1:0] addr;
    logic [7:0]             len;
  } ar_req_t;

endpackage

// File: rtl/dma_outst_cnt.sv
// Up/down saturating outstanding-burst counter.
// Flags whether another burst may be issued.
module dma_outst_cnt #(
  parameter int MAX_OUTST = 4,
  parameter int CW        = $clog2(MAX_OUTST + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          below_o,
  output logic          nz_o
);

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] LIM = CW'(MAX_OUTST);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: inc and dec together cancel; dec at zero saturates.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc_i, dec_i})
      2'b10:   cnt_d = cnt_q + ONE;
      2'b01:   cnt_d = (cnt_q == '0) ? '0 : cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // A completion with nothing outstanding is a protocol error.
  always_ff @(posedge clk_i) begin
    if (rst_ni && dec_i && !inc_i)
      assert (cnt_q != '0)
        else $error("outstanding counter underflow");
  end

  assign cnt_o   = cnt_q;
  assign below_o = cnt_q < LIM;
  assign nz_o    = cnt_q != '0;

endmodule

// File: rtl/dma_axi_rd_arbiter.sv
// Two-requester AXI4 read-channel arbiter.
// Round-robin AR slot, per-requester burst limit, R demux on rid MSB.
module dma_axi_rd_arbiter
  import dma_sg_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ID_WIDTH-2:0]   s0_arid,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ID_WIDTH-2:0]   s1_arid,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [ID_WIDTH-2:0]   s0_rid,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [ID_WIDTH-2:0]   s1_rid,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [ID_WIDTH-1:0]   m_rid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  busy
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  logic          arvalid_q, arvalid_d;
  logic          rr_q, rr_d;
  ar_req_t       slot_q, slot_d, req;
  logic          slot_free;
  logic          elig0, elig1;
  logic          win0, win1;
  logic          acc0, acc1;
  logic          below0, below1;
  logic          nz0, nz1;
  logic          rsel;
  logic          dec0, dec1;
  logic [CW-1:0] cnt0, cnt1;

  assign slot_free = !arvalid_q || m_arready;
  assign elig0     = s0_arvalid && below0;
  assign elig1     = s1_arvalid && below1;

  // Winner: lone eligible requester, else the one rr points at.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (elig0 && elig1) begin
      win0 = !rr_q;
      win1 = rr_q;
    end else begin
      win0 = elig0;
      win1 = elig1;
    end
  end

  assign s0_arready = slot_free && win0;
  assign s1_arready = slot_free && win1;
  assign acc0       = s0_arready;
  assign acc1       = s1_arready;

  // Winning payload, tagged with the requester index in the ID MSB.
  always_comb begin
    req = '0;
    if (win1) begin
      req.id   = AR_ID_MAX'({1'b1, s1_arid});
      req.addr = AR_ADDR_MAX'(s1_araddr);
      req.len  = s1_arlen;
    end else begin
      req.id   = AR_ID_MAX'({1'b0, s0_arid});
      req.addr = AR_ADDR_MAX'(s0_araddr);
      req.len  = s0_arlen;
    end
  end

  // Slot next state: refill on handshake, pointer moves to the loser.
  always_comb begin
    arvalid_d = arvalid_q;
    slot_d    = slot_q;
    rr_d      = rr_q;
    if (slot_free) arvalid_d = acc0 || acc1;
    if (acc0 || acc1) begin
      slot_d = req;
      rr_d   = acc0;
    end
  end

  // AR slot and round-robin pointer registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arvalid_q <= 1'b0;
      slot_q    <= '0;
      rr_q      <= 1'b0;
    end else begin
      arvalid_q <= arvalid_d;
      slot_q    <= slot_d;
      rr_q      <= rr_d;
    end
  end

  assign m_arvalid = arvalid_q;
  assign m_arid    = slot_q.id[ID_WIDTH-1:0];
  assign m_araddr  = slot_q.addr[ADDR_WIDTH-1:0];
  assign m_arlen   = slot_q.len;

  logic unused_slot;
  assign unused_slot = ^{slot_q.id[AR_ID_MAX-1:ID_WIDTH],
                         slot_q.addr[AR_ADDR_MAX-1:ADDR_WIDTH]};

  // R demux: the ID MSB names the owner; ready only while a beat is up.
  assign rsel      = m_rid[ID_WIDTH-1];
  assign s0_rvalid = m_rvalid && !rsel;
  assign s1_rvalid = m_rvalid && rsel;
  assign m_rready  = m_rvalid && (rsel ? s1_rready : s0_rready);

  assign s0_rid   = m_rid[ID_WIDTH-2:0];
  assign s1_rid   = m_rid[ID_WIDTH-2:0];
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s1_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rlast = m_rlast;

  assign dec0 = m_rvalid && m_rready && m_rlast && !rsel;
  assign dec1 = m_rvalid && m_rready && m_rlast && rsel;

  dma_outst_cnt #(
    .MAX_OUTST (MAX_OUTST),
    .CW        (CW)
  ) u_cnt0 (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .inc_i   (acc0),
    .dec_i   (dec0),
    .cnt_o   (cnt0),
    .below_o (below0),
    .nz_o    (nz0)
  );

  dma_outst_cnt #(
    .MAX_OUTST (MAX_OUTST),
    .CW        (CW)
  ) u_cnt1 (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .inc_i   (acc1),
    .dec_i   (dec1),
    .cnt_o   (cnt1),
    .below_o (below1),
    .nz_o    (nz1)
  );

  logic unused_cnt;
  assign unused_cnt = ^{cnt0, cnt1};

  assign busy = arvalid_q || nz0 || nz1;

endmodule

// File: tb/tb_dma_axi_rd_arbiter.sv
// Directed bench for dma_axi_rd_arbiter.
// Expected values are hand-computed per step.
module tb_dma_axi_rd_arbiter;

  logic        ACLK;
  logic        ARESETN;
  logic [2:0]  s0_arid, s1_arid;
  logic [31:0] s0_araddr, s1_araddr;
  logic [7:0]  s0_arlen, s1_arlen;
  logic        s0_arvalid, s1_arvalid;
  logic        s0_arready, s1_arready;
  logic [2:0]  s0_rid, s1_rid;
  logic [63:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_rresp, s1_rresp;
  logic        s0_rlast, s1_rlast;
  logic        s0_rvalid, s1_rvalid;
  logic        s0_rready, s1_rready;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid, m_arready;
  logic [3:0]  m_rid;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, m_rvalid, m_rready;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  dma_axi_rd_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clr_inputs();
    s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_arvalid = 1'b0;
    s1_arid = '0; s1_araddr = '0; s1_arlen = '0; s1_arvalid = 1'b0;
    s0_rready = 1'b0; s1_rready = 1'b0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0;
    m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    clr_inputs();
    #2;
    ARESETN = 1'b1;
  endtask

  initial begin
    ARESETN = 1'b0;
    clr_inputs();
    #2;
    chk("rst_arvalid_async", m_arvalid, 0);
    #10;
    chk("rst_arid", m_arid, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s0_arready", s0_arready, 0);
    chk("rst_m_rready", m_rready, 0);
    ARESETN = 1'b1;

    // 1: single request and 4-beat return
    tick();
    s0_arvalid = 1; s0_araddr = 32'h1000; s0_arlen = 3; s0_arid = 2;
    m_arready = 1;
    #1;
    chk("t1_s0_arready", s0_arready, 1);
    chk("t1_s1_arready", s1_arready, 0);
    tick();
    s0_arvalid = 0;
    chk("t1_arvalid", m_arvalid, 1);
    chk("t1_arid", m_arid, 4'h2);
    chk("t1_araddr", m_araddr, 32'h1000);
    chk("t1_arlen", m_arlen, 3);
    chk("t1_cnt0", dut.u_cnt0.cnt_o, 1);
    tick();
    chk("t1_arvalid_clr", m_arvalid, 0);
    chk("t1_busy_outst", busy, 1);
    m_rvalid = 1; m_rid = 4'h2; s0_rready = 1;
    for (int b = 0; b < 4; b++) begin
      m_rdata = 64'hA0 + 64'(b);
      m_rlast = (b == 3);
      #1;
      chk("t1_s0_rvalid", s0_rvalid, 1);
      chk("t1_s1_rvalid", s1_rvalid, 0);
      chk("t1_m_rready", m_rready, 1);
      chk("t1_s0_rdata", s0_rdata, 64'hA0 + 64'(b));
      chk("t1_s0_rid", s0_rid, 2);
      tick();
    end
    m_rvalid = 0; m_rlast = 0;
    #1;
    chk("t1_cnt0_done", dut.u_cnt0.cnt_o, 0);
    chk("t1_busy_done", busy, 0);

    // 2: round-robin between two always-valid requesters
    do_reset();
    tick();
    s0_arvalid = 1; s0_arid = 1; s0_araddr = 32'h100;
    s1_arvalid = 1; s1_arid = 5; s1_araddr = 32'h200;
    m_arready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_s0_arready", s0_arready, (i % 2) == 0);
      chk("t2_s1_arready", s1_arready, (i % 2) == 1);
      tick();
      chk("t2_arid", m_arid, ((i % 2) == 1) ? 4'hD : 4'h1);
    end
    chk("t2_cnt0", dut.u_cnt0.cnt_o, 4);
    chk("t2_cnt1", dut.u_cnt1.cnt_o, 4);
    chk("t2_s0_lim", s0_arready, 0);
    chk("t2_s1_lim", s1_arready, 0);

    // 3: AR backpressure holds slot, release accepts same cycle
    do_reset();
    tick();
    s0_arvalid = 1; s0_araddr = 32'h2000; s0_arlen = 7; s0_arid = 3;
    m_arready = 0;
    #1;
    chk("t3_s0_arready", s0_arready, 1);
    tick();
    s0_araddr = 32'h3000; s0_arlen = 1; s0_arid = 4;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_valid", m_arvalid, 1);
      chk("t3_hold_addr", m_araddr, 32'h2000);
      chk("t3_hold_len", m_arlen, 7);
      chk("t3_hold_id", m_arid, 3);
      chk("t3_hold_s0rdy", s0_arready, 0);
      chk("t3_hold_s1rdy", s1_arready, 0);
      tick();
    end
    m_arready = 1;
    #1;
    chk("t3_release_rdy", s0_arready, 1);
    tick();
    s0_arvalid = 0;
    chk("t3_next_addr", m_araddr, 32'h3000);
    chk("t3_next_id", m_arid, 4);
    chk("t3_next_len", m_arlen, 1);
    chk("t3_cnt0", dut.u_cnt0.cnt_o, 2);
    tick();
    chk("t3_slot_clr", m_arvalid, 0);

    // 5: R routing under backpressure, simultaneous inc/dec
    s0_rready = 1; s1_rready = 0;
    m_rvalid = 1; m_rlast = 0; m_rid = 4'h3;
    #1;
    chk("t5_rready_s0", m_rready, 1);
    chk("t5_s0_rvalid", s0_rvalid, 1);
    chk("t5_s1_rvalid_n", s1_rvalid, 0);
    tick();
    m_rid = 4'h9;
    #1;
    chk("t5_rready_s1", m_rready, 0);
    chk("t5_s1_rvalid", s1_rvalid, 1);
    chk("t5_s0_rvalid_n", s0_rvalid, 0);
    chk("t5_s1_rid", s1_rid, 1);
    tick();
    m_rid = 4'h3; m_rlast = 1;
    s0_arvalid = 1; s0_araddr = 32'h5000; s0_arlen = 0; s0_arid = 5;
    #1;
    chk("t5_sim_rready", m_rready, 1);
    chk("t5_sim_arready", s0_arready, 1);
    tick();
    chk("t5_sim_cnt0", dut.u_cnt0.cnt_o, 2);
    s0_arvalid = 0; m_rvalid = 0;
    tick();
    m_rvalid = 1; m_rid = 4'h3; m_rlast = 1;
    tick();
    tick();
    m_rvalid = 0; m_rlast = 0;
    #1;
    chk("t5_drain_cnt0", dut.u_cnt0.cnt_o, 0);
    chk("t5_drain_busy", busy, 0);

    // 4: outstanding limit on s1
    do_reset();
    tick();
    m_arready = 1;
    s1_arvalid = 1; s1_arid = 0; s1_araddr = 32'h4000; s1_arlen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_s1_acc", s1_arready, 1);
      tick();
    end
    chk("t4_cnt1_full", dut.u_cnt1.cnt_o, 4);
    s0_arvalid = 1; s0_arid = 1; s0_araddr = 32'h6000;
    #1;
    chk("t4_s1_stall", s1_arready, 0);
    chk("t4_s0_grant", s0_arready, 1);
    tick();
    s0_arvalid = 0;
    #1;
    chk("t4_s1_still", s1_arready, 0);
    m_rvalid = 1; m_rid = 4'h8; m_rlast = 1; s1_rready = 1;
    #1;
    chk("t4_rlast_rdy", m_rready, 1);
    chk("t4_rlast_s1v", s1_rvalid, 1);
    chk("t4_rlast_s0v", s0_rvalid, 0);
    tick();
    m_rvalid = 0; m_rlast = 0;
    #1;
    chk("t4_cnt1_dec", dut.u_cnt1.cnt_o, 3);
    chk("t4_unblock", s1_arready, 1);
    tick();
    chk("t4_cnt1_refill", dut.u_cnt1.cnt_o, 4);
    chk("t4_fifth_id", m_arid, 4'h8);
    chk("t4_fifth_addr", m_araddr, 32'h4000);
    s1_arvalid = 0;

    // 6: asynchronous reset mid-burst
    s0_arvalid = 1; s0_arid = 2; s0_araddr = 32'h7000; s0_arlen = 5;
    #1;
    chk("t6_s0_acc", s0_arready, 1);
    tick();
    s0_arvalid = 0; m_arready = 0;
    m_rvalid = 1; m_rid = 4'h8; m_rlast = 0; s1_rready = 1;
    tick();
    chk("t6_busy_pre", busy, 1);
    chk("t6_arvalid_pre", m_arvalid, 1);
    chk("t6_cnt0_pre", dut.u_cnt0.cnt_o, 2);
    #2;
    ARESETN = 0;
    m_rvalid = 0;
    #1;
    chk("t6_arvalid", m_arvalid, 0);
    chk("t6_arid", m_arid, 0);
    chk("t6_araddr", m_araddr, 0);
    chk("t6_arlen", m_arlen, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cnt0", dut.u_cnt0.cnt_o, 0);
    chk("t6_cnt1", dut.u_cnt1.cnt_o, 0);
    chk("t6_s0_arready", s0_arready, 0);
    chk("t6_s1_arready", s1_arready, 0);
    chk("t6_m_rready", m_rready, 0);
    chk("t6_s1_rvalid", s1_rvalid, 0);
    #2;
    ARESETN = 1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
